// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-ported memory bus, with bus lock
// and a read-return pipeline that tags each read with the requester that issued it.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  // Handshake: a requester holds req until it sees gnt; an access transfers in
  // exactly the cycle where req & gnt are both high, and gnt never precedes req.

  logic              last;
  logic              lock_valid;
  logic              lock_owner;
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_owner;

  logic g0;
  logic g1;
  logic gnt_any;
  logic gnt_we;
  logic gnt_lock;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      if (lock_valid) begin
        // The non-owner stays blocked even while the owner is idle.
        if (lock_owner) g1 = p1_req;
        else            g0 = p0_req;
      end else if (p0_req && p1_req) begin
        if (last) g0 = 1'b1;
        else      g1 = 1'b1;
      end else begin
        g0 = p0_req;
        g1 = p1_req;
      end
    end
  end

  assign gnt_any  = g0 | g1;
  assign gnt_we   = g1 ? p1_we   : p0_we;
  assign gnt_lock = g1 ? p1_lock : p0_lock;

  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign mem_addr  = g1 ? p1_addr  : p0_addr;
  assign mem_wdata = g1 ? p1_wdata : p0_wdata;
  assign mem_re    = gnt_any & ~gnt_we;
  assign mem_we    = gnt_any & gnt_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last       <= 1'b1;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      if (gnt_any) begin
        last <= g1;
        if (gnt_lock) begin
          lock_valid <= 1'b1;
          lock_owner <= g1;
        end else if (lock_valid && (g1 == lock_owner)) begin
          lock_valid <= 1'b0;
        end
      end
      pipe_valid[0] <= mem_re;
      pipe_owner[0] <= g1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end

  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  assign p0_rvalid = rst & pipe_valid[RD_LAT-1] & ~pipe_owner[RD_LAT-1];
  assign p1_rvalid = rst & pipe_valid[RD_LAT-1] &  pipe_owner[RD_LAT-1];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-ported 16-bit memory bus between the CPU and the memory model. It grants one access per cycle, round-robin, with no added request latency. A lock lets a requester hold the bus across multi-cycle atomic sequences. Read data comes back from a delay pipeline that tracks which requester issued each read.

## Interface
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles (legal 1..4); mem_rdata is valid RD_LAT cycles after mem_re
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- pN_req  input  1  access request, N = 0,1; held until granted
- pN_we  input  1  1 = write, 0 = read; qualified by pN_req
- pN_lock  input  1  keep ownership after this grant
- pN_addr  input  AW  address
- pN_wdata  input  DW  write data
- pN_gnt  output  1  access accepted this cycle
- pN_rdata  output  DW  read data; mem_rdata broadcast to both ports
- pN_rvalid  output  1  one-cycle pulse; pN_rdata holds this port's read result
- mem_addr  output  AW  to memory
- mem_wdata  output  DW  to memory
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- mem_rdata  input  DW  from memory

## Operation
- **Grant logic:** combinational from the current requests and registered state. At most one of p0_gnt/p1_gnt is high in a cycle.
- **Registered state:**
  - last (1 bit): port granted most recently.
  - lock_valid, lock_owner: lock status and holder.
  - rd_pipe[RD_LAT]: per-stage {valid, owner}.
- **Unlocked arbitration:**
  - Exactly one port requesting: that port is granted.
  - Both ports requesting: the port != last is granted.
- **Locked arbitration:**
  - Only lock_owner may be granted.
  - The other port's req waits with gnt = 0, even when the owner is idle.
- **Lock update on a grant:**
  - Granted port has lock = 1: lock_valid <= 1 and lock_owner <= that port.
  - Owner is granted with lock = 0: lock_valid <= 0, taking effect next cycle.
  - pN_lock without a grant has no effect.
- **last update:** on any grant, last <= the granted port.
- **Memory side:**
  - mem_addr and mem_wdata come from the granted port. When nothing is granted they come from p0, but the strobes are low.
  - mem_re = gnt & ~we.
  - mem_we = gnt & we.
  - mem_re and mem_we are never high together.
- **Read return:**
  - Stage 0 of rd_pipe captures {mem_re, granted port}.
  - Each stage shifts by one every cycle.
  - Final stage valid pulses pN_rvalid for the owner port only.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- **Writes:** complete at the grant edge and produce no rvalid.

## Timing
- Zero-cycle issue: memory sees the request in the same cycle gnt is high.
- Read data is available RD_LAT cycles after the grant cycle, coincident with pN_rvalid.
- Throughput: one access per cycle. Full bandwidth alternates p0/p1 under contention.
- **Reset (rst = 0 at a clock edge):**
  - last <= 1, so p0 wins the first tie.
  - lock_valid <= 0.
  - All rd_pipe valid bits <= 0.
- **Outputs while rst = 0:**
  - gnt, mem_re, mem_we and rvalid are forced to 0.
  - rdata follows mem_rdata.
- **Reset mid-operation:** in-flight reads are discarded and no rvalid is produced for them. A lock is released.
- Requests during reset are ignored. They are arbitrated normally on the first cycle with rst = 1.
- A request dropped before grant is legal and leaves no state behind.
- The lock holder may drop req while locked. The bus idles and the other port stays blocked until the owner completes an access with lock = 0.

## Test plan
- **Single requester, RD_LAT=1:** p0 read of 0x0010 (memory holds 0xBEEF) -> p0_gnt and mem_re high in the same cycle; p0_rvalid=1, p0_rdata=0xBEEF next cycle; p1_rvalid stays 0.
- **Contention:** p0 and p1 both hold req for 4 cycles, first cycle after reset -> grants p0, p1, p0, p1; mem_re or mem_we high every cycle.
- **Read ordering, RD_LAT=3:** p0 reads 0x0001 then p1 reads 0x0002 (data 0x1111, 0x2222) -> p0_rvalid carries 0x1111 three cycles after its grant; p1_rvalid carries 0x2222 one cycle later.
- **Lock:** p1 is granted a write with lock=1 while p0 requests -> p0_gnt stays 0 through three p1 locked accesses; after p1's access with lock=0, p0 is granted the following cycle.
- **Reset mid-read, RD_LAT=2:** p0 read is granted, then rst=0 on the next edge -> no p0_rvalid ever appears for that read; lock is cleared; after rst=1, simultaneous requests grant p0 first.
- **Write path:** p1 writes 0xA5A5 to 0x0100, then p0 reads 0x0100 -> mem_we for exactly one cycle; p0_rdata=0xA5A5; no rvalid follows the write.
